pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Merges stall requests from IF, ID, EX and MEM into a per-stage hold vector that drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Takes branch/jump redirects from EX and issues the PC redirect plus a flush that turns the IF/ID and ID/EX registers into NOPs.
- If a redirect arrives while the back end is stalled, the block holds it pending and replays it when the stall releases. It also keeps stall statistics and a MEM-stall watchdog.

Parameters:
- TIMEOUT, 255: consecutive stallreq_mem cycles that set stall_timeout_o.
- CNT_W, 8: width of the watchdog counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stallreq_if  input  1  IF requests a hold (instruction fetch not ready).
- stallreq_id  input  1  ID requests a hold (load-use hazard).
- stallreq_ex  input  1  EX requests a hold (multi-cycle ALU op).
- stallreq_mem  input  1  MEM requests a hold (data memory not ready).
- branch_flag_i  input  1  one-cycle pulse from EX: taken branch or jump.
- branch_target_i  input  32  redirect address, valid with branch_flag_i.
- stall_o  output  6  hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush_o  output  1  clear IF/ID and ID/EX to NOP this cycle.
- new_pc_valid_o  output  1  PC loads new_pc_o this cycle.
- new_pc_o  output  32  redirect address.
- stall_cycles_o  output  32  saturating count of cycles with stall_o != 0.
- stall_timeout_o  output  1  sticky; watchdog expired.

Behaviour:
- Reset (synchronous, active-high):
  - While rst=1, every output is forced to 0, including the combinational outputs.
  - On the next clock edge, the state returns to IDLE, the pending registers are cleared, both counters are cleared and stall_timeout_o is cleared.
  - Asserting reset in the middle of a pending redirect discards the redirect.
- Stall vector (combinational, zero latency, fixed priority MEM > EX > ID > IF):
  - stallreq_mem gives 6'b011111.
  - Else stallreq_ex gives 6'b001111.
  - Else stallreq_id gives 6'b000111.
  - Else stallreq_if gives 6'b000011.
  - Else 6'b000000.
- Backend stall: bstall = stallreq_mem | stallreq_ex.
- State machine, states IDLE and PEND:
  - IDLE, branch_flag_i=1, bstall=0: flush_o=1, new_pc_valid_o=1, new_pc_o=branch_target_i, all in the same cycle. Stay in IDLE.
  - IDLE, branch_flag_i=1, bstall=1: capture branch_target_i into pend_pc and go to PEND. No flush and no redirect in this cycle.
  - PEND, bstall=1: hold. flush_o=0 and new_pc_valid_o=0.
  - PEND, bstall=0: flush_o=1, new_pc_valid_o=1, new_pc_o=pend_pc. Go to IDLE on the next edge.
  - PEND, branch_flag_i=1 (protocol violation): pend_pc is overwritten with the newest target (latest wins). The state stays PEND.
  - PEND, bstall=0 and branch_flag_i=1 in the same cycle: the live branch_target_i wins and the state goes to IDLE.
- Flush masking:
  - In any cycle with flush_o=1, stallreq_id and stallreq_if are ignored when forming stall_o. With bstall=0 this gives stall_o=0, so the redirect takes effect and the wrong-path instructions are killed.
- new_pc_o when new_pc_valid_o=0:
  - Shows pend_pc in PEND.
  - Shows 0 in IDLE.
- stall_cycles_o:
  - Increments on each edge where stall_o != 0 and rst=0.
  - Saturates at 32'hFFFFFFFF; it does not wrap.
- Watchdog:
  - The CNT_W-bit counter increments while stallreq_mem=1 and clears in any cycle where stallreq_mem=0.
  - On the edge where the counter reaches TIMEOUT, stall_timeout_o is set to 1.
  - stall_timeout_o clears only on reset.
  - The counter saturates at TIMEOUT.

Test Plan:
- Reset held 3 cycles with all requests at 1 -> every output 0 throughout; on release with requests 0, stall_o=000000 and stall_cycles_o=0.
- Priority checks:
  - stallreq_id=1 alone -> stall_o=000111.
  - stallreq_id=1 with stallreq_mem=1 -> stall_o=011111.
  - stallreq_if=1 alone -> stall_o=000011.
  - After 5 stalled cycles, stall_cycles_o=5.
- branch_flag_i pulse with target 0x00001000 and no stall, stallreq_id=1 in the same cycle -> in that cycle flush_o=1, new_pc_valid_o=1, new_pc_o=0x00001000, stall_o=000000.
- stallreq_mem=1 for 4 cycles, branch pulse with target 0x00000200 in the 1st cycle -> no flush for 4 cycles; in the cycle stallreq_mem drops, flush_o=1 and new_pc_o=0x00000200 for exactly 1 cycle; then IDLE.
- Pending redirect active (target 0x300), rst=1 for 1 cycle, then stalls drop -> no flush and no redirect is ever issued.
- TIMEOUT=4, stallreq_mem=1 for 3 cycles, 0 for 1 cycle, then 1 for 4 cycles -> stall_timeout_o rises only at the end of the 4th cycle of the second run and stays 1 after stallreq_mem drops.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges stage stall requests into a hold vector,
// issues (or defers and replays) EX branch redirects with a front-end flush, and tracks stall statistics.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        new_pc_valid_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cycles_o,
  output logic        stall_timeout_o
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [31:0]      pend_pc, pend_pc_nxt;
  logic             bstall;
  logic             flush, pc_valid;
  logic [31:0]      pc_mux;
  logic [5:0]       stall_vec;
  logic [31:0]      stall_cnt;
  logic [CNT_W-1:0] wd_cnt;
  logic             timeout;

  assign bstall = stallreq_mem | stallreq_ex;

  // A redirect that arrives during a back-end stall is parked in pend_pc and replayed on release.
  always_comb begin
    state_nxt   = state;
    pend_pc_nxt = pend_pc;
    flush       = 1'b0;
    pc_valid    = 1'b0;
    pc_mux      = 32'h0;
    case (state)
      IDLE: begin
        if (branch_flag_i) begin
          if (!bstall) begin
            flush    = 1'b1;
            pc_valid = 1'b1;
            pc_mux   = branch_target_i;
          end else begin
            state_nxt   = PEND;
            pend_pc_nxt = branch_target_i;
          end
        end
      end
      PEND: begin
        pc_mux = pend_pc;
        if (!bstall) begin
          flush     = 1'b1;
          pc_valid  = 1'b1;
          pc_mux    = branch_flag_i ? branch_target_i : pend_pc;
          state_nxt = IDLE;
        end else if (branch_flag_i) begin
          pend_pc_nxt = branch_target_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Front-end requests are dropped while flushing so the redirect is never held off.
  always_comb begin
    stall_vec = 6'b000000;
    if (stallreq_mem)                stall_vec = 6'b011111;
    else if (stallreq_ex)            stall_vec = 6'b001111;
    else if (stallreq_id && !flush)  stall_vec = 6'b000111;
    else if (stallreq_if && !flush)  stall_vec = 6'b000011;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_pc   <= 32'h0;
      stall_cnt <= 32'h0;
      wd_cnt    <= '0;
      timeout   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_pc_nxt;
      if (stall_vec != 6'b000000 && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (!stallreq_mem) begin
        wd_cnt <= '0;
      end else if (wd_cnt != TIMEOUT_C) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == TIMEOUT_M1)
          timeout <= 1'b1;
      end
    end
  end

  // Reset blanks every output immediately, not just after the next edge.
  assign stall_o         = rst ? 6'b000000 : stall_vec;
  assign flush_o         = rst ? 1'b0      : flush;
  assign new_pc_valid_o  = rst ? 1'b0      : pc_valid;
  assign new_pc_o        = rst ? 32'h0     : pc_mux;
  assign stall_cycles_o  = rst ? 32'h0     : stall_cnt;
  assign stall_timeout_o = rst ? 1'b0      : timeout;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (TIMEOUT=4): reset blanking, stall priority, redirects,
// deferred redirect replay and discard, and the MEM-stall watchdog.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [5:0]  stall_o;
  logic        flush_o, new_pc_valid_o, stall_timeout_o;
  logic [31:0] new_pc_o, stall_cycles_o;

  int checks = 0;
  int passed = 0;

  pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_if     (stallreq_if),
    .stallreq_id     (stallreq_id),
    .stallreq_ex     (stallreq_ex),
    .stallreq_mem    (stallreq_mem),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_valid_o  (new_pc_valid_o),
    .new_pc_o        (new_pc_o),
    .stall_cycles_o  (stall_cycles_o),
    .stall_timeout_o (stall_timeout_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s_if, input logic s_id,
                               input logic s_ex, input logic s_mem,
                               input logic br, input logic [31:0] tgt);
    rst             = r;
    stallreq_if     = s_if;
    stallreq_id     = s_id;
    stallreq_ex     = s_ex;
    stallreq_mem    = s_mem;
    branch_flag_i   = br;
    branch_target_i = tgt;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"},   {26'h0, stall_o}, 32'h0);
    checkOutput({tag, "_flush"},   {31'h0, flush_o}, 32'h0);
    checkOutput({tag, "_valid"},   {31'h0, new_pc_valid_o}, 32'h0);
    checkOutput({tag, "_newpc"},   new_pc_o, 32'h0);
    checkOutput({tag, "_cycles"},  stall_cycles_o, 32'h0);
    checkOutput({tag, "_timeout"}, {31'h0, stall_timeout_o}, 32'h0);
  endtask

  initial begin
    // Reset held three cycles with everything asserted
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF);
      checkAllZero("reset");
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("rel_stall", {26'h0, stall_o}, 32'h0);
    checkOutput("rel_cycles", stall_cycles_o, 32'h0);
    checkOutput("rel_timeout", {31'h0, stall_timeout_o}, 32'h0);

    // Priority encoding, five stalled cycles
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
    checkOutput("prio_id", {26'h0, stall_o}, 32'h07);
    tick();
    applyStimulus(0, 0, 1, 0, 1, 0, 32'h0);
    checkOutput("prio_mem_id", {26'h0, stall_o}, 32'h1F);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("prio_if", {26'h0, stall_o}, 32'h03);
    tick();
    applyStimulus(0, 1, 0, 1, 0, 0, 32'h0);
    checkOutput("prio_ex_if", {26'h0, stall_o}, 32'h0F);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("cycles_5", stall_cycles_o, 32'd5);

    // Immediate redirect masks the ID stall
    applyStimulus(0, 0, 1, 0, 0, 1, 32'h0000_1000);
    checkOutput("br_flush", {31'h0, flush_o}, 32'h1);
    checkOutput("br_valid", {31'h0, new_pc_valid_o}, 32'h1);
    checkOutput("br_newpc", new_pc_o, 32'h0000_1000);
    checkOutput("br_stall", {26'h0, stall_o}, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("br_after_flush", {31'h0, flush_o}, 32'h0);
    checkOutput("br_after_newpc", new_pc_o, 32'h0);
    checkOutput("br_cycles", stall_cycles_o, 32'd5);

    // Redirect deferred behind a 4-cycle MEM stall
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_0200);
    checkOutput("pend_c1_flush", {31'h0, flush_o}, 32'h0);
    checkOutput("pend_c1_valid", {31'h0, new_pc_valid_o}, 32'h0);
    checkOutput("pend_c1_stall", {26'h0, stall_o}, 32'h1F);
    for (int i = 2; i <= 4; i++) begin
      tick();
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
      checkOutput("pend_hold_flush", {31'h0, flush_o}, 32'h0);
      checkOutput("pend_hold_newpc", new_pc_o, 32'h0000_0200);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("replay_flush", {31'h0, flush_o}, 32'h1);
    checkOutput("replay_valid", {31'h0, new_pc_valid_o}, 32'h1);
    checkOutput("replay_newpc", new_pc_o, 32'h0000_0200);
    checkOutput("replay_stall", {26'h0, stall_o}, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("replay_done_flush", {31'h0, flush_o}, 32'h0);
    checkOutput("replay_done_newpc", new_pc_o, 32'h0);
    checkOutput("replay_cycles", stall_cycles_o, 32'd9);
    checkOutput("replay_timeout", {31'h0, stall_timeout_o}, 32'h1);

    // Reset discards a pending redirect
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_0300);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
    checkOutput("disc_pend_newpc", new_pc_o, 32'h0000_0300);
    applyStimulus(1, 0, 0, 0, 1, 0, 32'h0);
    checkAllZero("disc_rst");
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("disc_flush", {31'h0, flush_o}, 32'h0);
      checkOutput("disc_valid", {31'h0, new_pc_valid_o}, 32'h0);
      checkOutput("disc_newpc", new_pc_o, 32'h0);
      checkOutput("disc_cycles", stall_cycles_o, 32'h0);
      checkOutput("disc_timeout", {31'h0, stall_timeout_o}, 32'h0);
      tick();
    end

    // Latest pending target wins; live target wins on release
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_0400);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_0500);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
    checkOutput("latest_pend_newpc", new_pc_o, 32'h0000_0500);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("latest_valid", {31'h0, new_pc_valid_o}, 32'h1);
    checkOutput("latest_newpc", new_pc_o, 32'h0000_0500);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_0600);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0700);
    checkOutput("live_flush", {31'h0, flush_o}, 32'h1);
    checkOutput("live_newpc", new_pc_o, 32'h0000_0700);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("live_done_valid", {31'h0, new_pc_valid_o}, 32'h0);
    checkOutput("live_done_newpc", new_pc_o, 32'h0);
    checkOutput("wd_start", {31'h0, stall_timeout_o}, 32'h0);

    // Watchdog: run of 3 is interrupted, run of 4 expires
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
      tick();
      checkOutput("wd_run1", {31'h0, stall_timeout_o}, 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    checkOutput("wd_gap", {31'h0, stall_timeout_o}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
      tick();
      checkOutput("wd_run2", {31'h0, stall_timeout_o}, (i == 4) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
      tick();
      checkOutput("wd_sticky", {31'h0, stall_timeout_o}, 32'h1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
